// File: rtl/iram_axi_arb.sv
// Two-master to one-slave AXI4-Lite arbiter for the instruction RAM port.
// One transaction in flight; round-robin between masters, writes before reads within a master.
module iram_axi_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0 (core LSU)
  input  logic [AW-1:0]   m0_axi_awaddr,
  input  logic [2:0]      m0_axi_awprot,
  input  logic            m0_axi_awvalid,
  output logic            m0_axi_awready,
  input  logic [DW-1:0]   m0_axi_wdata,
  input  logic [DW/8-1:0] m0_axi_wstrb,
  input  logic            m0_axi_wvalid,
  output logic            m0_axi_wready,
  output logic [1:0]      m0_axi_bresp,
  output logic            m0_axi_bvalid,
  input  logic            m0_axi_bready,
  input  logic [AW-1:0]   m0_axi_araddr,
  input  logic [2:0]      m0_axi_arprot,
  input  logic            m0_axi_arvalid,
  output logic            m0_axi_arready,
  output logic [DW-1:0]   m0_axi_rdata,
  output logic [1:0]      m0_axi_rresp,
  output logic            m0_axi_rvalid,
  input  logic            m0_axi_rready,
  // master 1 (debug / loader)
  input  logic [AW-1:0]   m1_axi_awaddr,
  input  logic [2:0]      m1_axi_awprot,
  input  logic            m1_axi_awvalid,
  output logic            m1_axi_awready,
  input  logic [DW-1:0]   m1_axi_wdata,
  input  logic [DW/8-1:0] m1_axi_wstrb,
  input  logic            m1_axi_wvalid,
  output logic            m1_axi_wready,
  output logic [1:0]      m1_axi_bresp,
  output logic            m1_axi_bvalid,
  input  logic            m1_axi_bready,
  input  logic [AW-1:0]   m1_axi_araddr,
  input  logic [2:0]      m1_axi_arprot,
  input  logic            m1_axi_arvalid,
  output logic            m1_axi_arready,
  output logic [DW-1:0]   m1_axi_rdata,
  output logic [1:0]      m1_axi_rresp,
  output logic            m1_axi_rvalid,
  input  logic            m1_axi_rready,
  // iram slave port
  output logic [AW-1:0]   s_axi_awaddr,
  output logic [2:0]      s_axi_awprot,
  output logic            s_axi_awvalid,
  input  logic            s_axi_awready,
  output logic [DW-1:0]   s_axi_wdata,
  output logic [DW/8-1:0] s_axi_wstrb,
  output logic            s_axi_wvalid,
  input  logic            s_axi_wready,
  input  logic [1:0]      s_axi_bresp,
  input  logic            s_axi_bvalid,
  output logic            s_axi_bready,
  output logic [AW-1:0]   s_axi_araddr,
  output logic [2:0]      s_axi_arprot,
  output logic            s_axi_arvalid,
  input  logic            s_axi_arready,
  input  logic [DW-1:0]   s_axi_rdata,
  input  logic [1:0]      s_axi_rresp,
  input  logic            s_axi_rvalid,
  output logic            s_axi_rready,
  output logic            grant_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_e;

  state_e state_q;
  logic   grant_q, last_grant_q, aw_done_q, w_done_q;

  // Master request channels packed by master index so the grant can select them.
  logic [1:0]                 m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;
  logic [1:0][AW-1:0]         m_awaddr, m_araddr;
  logic [1:0][2:0]            m_awprot, m_arprot;
  logic [1:0][DW-1:0]         m_wdata;
  logic [1:0][DW/8-1:0]       m_wstrb;
  logic [1:0]                 m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [1:0][1:0]            m_bresp, m_rresp;
  logic [1:0][DW-1:0]         m_rdata;

  assign m_awvalid = {m1_axi_awvalid, m0_axi_awvalid};
  assign m_wvalid  = {m1_axi_wvalid,  m0_axi_wvalid};
  assign m_arvalid = {m1_axi_arvalid, m0_axi_arvalid};
  assign m_bready  = {m1_axi_bready,  m0_axi_bready};
  assign m_rready  = {m1_axi_rready,  m0_axi_rready};
  assign m_awaddr  = {m1_axi_awaddr,  m0_axi_awaddr};
  assign m_araddr  = {m1_axi_araddr,  m0_axi_araddr};
  assign m_awprot  = {m1_axi_awprot,  m0_axi_awprot};
  assign m_arprot  = {m1_axi_arprot,  m0_axi_arprot};
  assign m_wdata   = {m1_axi_wdata,   m0_axi_wdata};
  assign m_wstrb   = {m1_axi_wstrb,   m0_axi_wstrb};

  assign m0_axi_awready = m_awready[0];
  assign m0_axi_wready  = m_wready[0];
  assign m0_axi_bvalid  = m_bvalid[0];
  assign m0_axi_bresp   = m_bresp[0];
  assign m0_axi_arready = m_arready[0];
  assign m0_axi_rvalid  = m_rvalid[0];
  assign m0_axi_rdata   = m_rdata[0];
  assign m0_axi_rresp   = m_rresp[0];
  assign m1_axi_awready = m_awready[1];
  assign m1_axi_wready  = m_wready[1];
  assign m1_axi_bvalid  = m_bvalid[1];
  assign m1_axi_bresp   = m_bresp[1];
  assign m1_axi_arready = m_arready[1];
  assign m1_axi_rvalid  = m_rvalid[1];
  assign m1_axi_rdata   = m_rdata[1];
  assign m1_axi_rresp   = m_rresp[1];

  logic [1:0] wreq, req;
  logic       win, aw_fire, w_fire, aw_all, w_all;

  assign wreq = m_awvalid & m_wvalid;
  assign req  = wreq | m_arvalid;
  // On a tie the master that did not win last time goes next.
  assign win  = (&req) ? ~last_grant_q : req[1];

  assign aw_fire = s_axi_awvalid & s_axi_awready;
  assign w_fire  = s_axi_wvalid & s_axi_wready;
  assign aw_all  = aw_done_q | aw_fire;
  assign w_all   = w_done_q | w_fire;

  always_comb begin
    m_awready     = '0;
    m_wready      = '0;
    m_bvalid      = '0;
    m_bresp       = '0;
    m_arready     = '0;
    m_rvalid      = '0;
    m_rdata       = '0;
    m_rresp       = '0;
    s_axi_awaddr  = m_awaddr[grant_q];
    s_axi_awprot  = m_awprot[grant_q];
    s_axi_wdata   = m_wdata[grant_q];
    s_axi_wstrb   = m_wstrb[grant_q];
    s_axi_araddr  = m_araddr[grant_q];
    s_axi_arprot  = m_arprot[grant_q];
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    case (state_q)
      WADDR: begin
        s_axi_awvalid       = m_awvalid[grant_q] & ~aw_done_q;
        s_axi_wvalid        = m_wvalid[grant_q] & ~w_done_q;
        m_awready[grant_q]  = s_axi_awready & ~aw_done_q;
        m_wready[grant_q]   = s_axi_wready & ~w_done_q;
      end
      WRESP: begin
        m_bvalid[grant_q] = s_axi_bvalid;
        m_bresp[grant_q]  = s_axi_bresp;
        s_axi_bready      = m_bready[grant_q];
      end
      RADDR: begin
        s_axi_arvalid      = m_arvalid[grant_q];
        m_arready[grant_q] = s_axi_arready;
      end
      RRESP: begin
        m_rvalid[grant_q] = s_axi_rvalid;
        m_rdata[grant_q]  = s_axi_rdata;
        m_rresp[grant_q]  = s_axi_rresp;
        s_axi_rready      = m_rready[grant_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          grant_q <= win;
          state_q <= wreq[win] ? WADDR : RADDR;
        end
        WADDR: if (aw_all && w_all) begin
          state_q   <= WRESP;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_all;
          w_done_q  <= w_all;
        end
        WRESP: if (s_axi_bvalid && s_axi_bready) begin
          state_q      <= IDLE;
          last_grant_q <= grant_q;
        end
        RADDR: if (s_axi_arvalid && s_axi_arready) state_q <= RRESP;
        RRESP: if (s_axi_rvalid && s_axi_rready) begin
          state_q      <= IDLE;
          last_grant_q <= grant_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_iram_axi_arb.sv
// Directed bench for iram_axi_arb: two master drivers plus a small iram slave model.
module tb_iram_axi_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]   m_awaddr[2], m_araddr[2];
  logic [2:0]      m_awprot[2], m_arprot[2];
  logic [DW-1:0]   m_wdata[2], m_rdata[2];
  logic [DW/8-1:0] m_wstrb[2];
  logic [1:0]      m_bresp[2], m_rresp[2];
  logic            m_awvalid[2], m_awready[2], m_wvalid[2], m_wready[2];
  logic            m_bvalid[2], m_bready[2], m_arvalid[2], m_arready[2];
  logic            m_rvalid[2], m_rready[2];

  logic [AW-1:0]   s_axi_awaddr, s_axi_araddr;
  logic [2:0]      s_axi_awprot, s_axi_arprot;
  logic [DW-1:0]   s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic [1:0]      s_axi_bresp, s_axi_rresp;
  logic            s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic            s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic            s_axi_rvalid, s_axi_rready;
  logic            grant_o, busy_o;

  iram_axi_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_axi_awaddr(m_awaddr[0]), .m0_axi_awprot(m_awprot[0]), .m0_axi_awvalid(m_awvalid[0]),
    .m0_axi_awready(m_awready[0]), .m0_axi_wdata(m_wdata[0]), .m0_axi_wstrb(m_wstrb[0]),
    .m0_axi_wvalid(m_wvalid[0]), .m0_axi_wready(m_wready[0]), .m0_axi_bresp(m_bresp[0]),
    .m0_axi_bvalid(m_bvalid[0]), .m0_axi_bready(m_bready[0]), .m0_axi_araddr(m_araddr[0]),
    .m0_axi_arprot(m_arprot[0]), .m0_axi_arvalid(m_arvalid[0]), .m0_axi_arready(m_arready[0]),
    .m0_axi_rdata(m_rdata[0]), .m0_axi_rresp(m_rresp[0]), .m0_axi_rvalid(m_rvalid[0]),
    .m0_axi_rready(m_rready[0]),
    .m1_axi_awaddr(m_awaddr[1]), .m1_axi_awprot(m_awprot[1]), .m1_axi_awvalid(m_awvalid[1]),
    .m1_axi_awready(m_awready[1]), .m1_axi_wdata(m_wdata[1]), .m1_axi_wstrb(m_wstrb[1]),
    .m1_axi_wvalid(m_wvalid[1]), .m1_axi_wready(m_wready[1]), .m1_axi_bresp(m_bresp[1]),
    .m1_axi_bvalid(m_bvalid[1]), .m1_axi_bready(m_bready[1]), .m1_axi_araddr(m_araddr[1]),
    .m1_axi_arprot(m_arprot[1]), .m1_axi_arvalid(m_arvalid[1]), .m1_axi_arready(m_arready[1]),
    .m1_axi_rdata(m_rdata[1]), .m1_axi_rresp(m_rresp[1]), .m1_axi_rvalid(m_rvalid[1]),
    .m1_axi_rready(m_rready[1]),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr),
    .s_axi_arprot(s_axi_arprot), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  // Slave model: 16-word memory, awready held off for aw_delay cycles, optional rvalid block.
  logic [DW-1:0]   mem [16];
  bit              mem_init;
  int              aw_cnt, aw_delay, w_beats;
  logic [1:0]      cfg_bresp;
  logic            r_block, r_pend, have_aw, have_w;
  logic [AW-1:0]   sl_awaddr, wa;
  logic [2:0]      sl_awprot;
  logic [DW-1:0]   sl_wdata, wd;
  logic [DW/8-1:0] sl_wstrb;
  logic            sl_awf, sl_wf, sl_arf;

  assign s_axi_awready = (aw_cnt >= aw_delay);
  assign s_axi_wready  = 1'b1;
  assign s_axi_arready = 1'b1;
  assign sl_awf = s_axi_awvalid & s_axi_awready;
  assign sl_wf  = s_axi_wvalid & s_axi_wready;
  assign sl_arf = s_axi_arvalid & s_axi_arready;
  assign wa = sl_awf ? s_axi_awaddr : sl_awaddr;
  assign wd = sl_wf ? s_axi_wdata : sl_wdata;

  always @(posedge clk) begin
    if (rst) begin
      if (!mem_init) begin
        for (int i = 0; i < 16; i++) mem[i] <= '0;
        mem_init <= 1'b1;
      end
      have_aw <= 1'b0; have_w <= 1'b0; aw_cnt <= 0; r_pend <= 1'b0;
      s_axi_bvalid <= 1'b0; s_axi_rvalid <= 1'b0;
      s_axi_bresp <= '0; s_axi_rresp <= '0; s_axi_rdata <= '0;
    end else begin
      if (sl_awf) begin
        have_aw <= 1'b1; sl_awaddr <= s_axi_awaddr; sl_awprot <= s_axi_awprot; aw_cnt <= 0;
      end else if (s_axi_awvalid) aw_cnt <= aw_cnt + 1;
      if (sl_wf) begin
        have_w <= 1'b1; sl_wdata <= s_axi_wdata; sl_wstrb <= s_axi_wstrb; w_beats <= w_beats + 1;
      end
      if ((have_aw || sl_awf) && (have_w || sl_wf) && !s_axi_bvalid) begin
        mem[wa[5:2]] <= wd; s_axi_bvalid <= 1'b1; s_axi_bresp <= cfg_bresp;
        have_aw <= 1'b0; have_w <= 1'b0;
      end
      if (s_axi_bvalid && s_axi_bready) s_axi_bvalid <= 1'b0;
      if (sl_arf) begin
        s_axi_rdata <= mem[s_axi_araddr[5:2]]; s_axi_rresp <= 2'b00; r_pend <= 1'b1;
      end
      if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0; r_pend <= 1'b0;
      end else if ((r_pend || sl_arf) && !r_block) s_axi_rvalid <= 1'b1;
    end
  end

  // Grant history (one entry per transaction start) and m0 B-handshake count.
  bit gq[$];
  bit prev_busy;
  int b0_cnt;
  always @(posedge clk) begin
    if (busy_o && !prev_busy) gq.push_back(grant_o);
    prev_busy = busy_o;
    if (m_bvalid[0] && m_bready[0]) b0_cnt++;
  end

  int checks = 0;
  int failures = 0;

  // Drivers start and end just after a falling edge.
  task automatic do_write(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] st, output logic [1:0] resp, output bit ok);
    bit awf, wf;
    int n;
    m_awaddr[m] = a; m_awprot[m] = 3'b010; m_wdata[m] = d; m_wstrb[m] = st;
    m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; m_bready[m] = 1'b1;
    ok = 1'b0; resp = 2'b11; n = 0;
    while (!ok && n < 60) begin
      #1;
      awf = m_awvalid[m] && m_awready[m];
      wf  = m_wvalid[m] && m_wready[m];
      if (m_bvalid[m] && m_bready[m]) begin resp = m_bresp[m]; ok = 1'b1; end
      @(negedge clk); n++;
      if (awf) m_awvalid[m] = 1'b0;
      if (wf) m_wvalid[m] = 1'b0;
    end
    m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
  endtask

  task automatic do_read(input int m, input logic [AW-1:0] a, input int hold,
                         output logic [DW-1:0] data, output logic [1:0] resp, output bit ok);
    bit arf;
    int n, hc;
    m_araddr[m] = a; m_arprot[m] = 3'b001; m_arvalid[m] = 1'b1; m_rready[m] = (hold == 0);
    ok = 1'b0; data = '0; resp = 2'b11; n = 0; hc = 0;
    while (!ok && n < 60) begin
      #1;
      arf = m_arvalid[m] && m_arready[m];
      if (m_rvalid[m] && m_rready[m]) begin data = m_rdata[m]; resp = m_rresp[m]; ok = 1'b1; end
      else if (m_rvalid[m]) hc++;
      @(negedge clk); n++;
      if (arf) m_arvalid[m] = 1'b0;
      if (hc >= hold) m_rready[m] = 1'b1;
    end
    m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    m_arvalid[0] = 1'b1; m_araddr[0] = 32'h10;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    checks++;
    if (grant_o !== 1'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0", grant_o); end
    checks++;
    if ({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} !== 5'b0) begin
      failures++;
      $display("FAIL reset_slave_valids got=%b exp=00000",
               {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready});
    end
    checks++;
    if ({m_arready[0], m_awready[0], m_wready[0], m_bvalid[0], m_rvalid[0]} !== 5'b0) begin
      failures++; $display("FAIL reset_master_outs got=%b exp=00000",
                           {m_arready[0], m_awready[0], m_wready[0], m_bvalid[0], m_rvalid[0]});
    end
    @(negedge clk);
    m_arvalid[0] = 1'b0; rst = 1'b0;
  endtask

  task automatic test_single_write();
    logic [1:0] resp; logic [DW-1:0] d; bit ok;
    do_write(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, resp, ok);
    checks++;
    if (!ok || resp !== 2'b00) begin failures++; $display("FAIL wr_bresp got=%b ok=%0d exp=00", resp, ok); end
    checks++;
    if (sl_awaddr !== 32'h10) begin failures++; $display("FAIL wr_slave_awaddr got=%h exp=00000010", sl_awaddr); end
    checks++;
    if (sl_awprot !== 3'b010) begin failures++; $display("FAIL wr_slave_awprot got=%b exp=010", sl_awprot); end
    checks++;
    if (sl_wdata !== 32'hDEAD_BEEF || sl_wstrb !== 4'hF) begin
      failures++; $display("FAIL wr_slave_w got=%h/%h exp=deadbeef/f", sl_wdata, sl_wstrb);
    end
    do_read(1, 32'h0000_0010, 0, d, resp, ok);
    checks++;
    if (!ok || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd_back_m1 got=%h ok=%0d exp=deadbeef", d, ok); end
    checks++;
    if (grant_o !== 1'b1) begin failures++; $display("FAIL rd_back_grant got=%b exp=1", grant_o); end
  endtask

  task automatic test_wr_rd_prio();
    bit awf, wf, arf, bseen, rseen, ar_early;
    logic [1:0] bresp, rresp; logic [DW-1:0] rdata;
    int n;
    m_awaddr[1] = 32'h20; m_awprot[1] = 3'b000; m_wdata[1] = 32'h1234_5678; m_wstrb[1] = 4'hF;
    m_araddr[1] = 32'h20; m_arprot[1] = 3'b000;
    m_awvalid[1] = 1'b1; m_wvalid[1] = 1'b1; m_arvalid[1] = 1'b1;
    m_bready[1] = 1'b1; m_rready[1] = 1'b1;
    bseen = 0; rseen = 0; ar_early = 0; n = 0; bresp = 2'b11; rresp = 2'b11; rdata = '0;
    while (!rseen && n < 80) begin
      #1;
      awf = m_awvalid[1] && m_awready[1];
      wf  = m_wvalid[1] && m_wready[1];
      arf = m_arvalid[1] && m_arready[1];
      if (arf && !bseen) ar_early = 1;
      if (m_bvalid[1] && m_bready[1]) begin bresp = m_bresp[1]; bseen = 1; end
      if (m_rvalid[1] && m_rready[1]) begin rdata = m_rdata[1]; rresp = m_rresp[1]; rseen = 1; end
      @(negedge clk); n++;
      if (awf) m_awvalid[1] = 1'b0;
      if (wf) m_wvalid[1] = 1'b0;
      if (arf) m_arvalid[1] = 1'b0;
    end
    m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0; m_arvalid[1] = 1'b0;
    m_bready[1] = 1'b0; m_rready[1] = 1'b0;
    checks++;
    if (ar_early !== 1'b0 || !bseen) begin failures++; $display("FAIL prio_write_first ar_early=%0d bseen=%0d exp=0/1", ar_early, bseen); end
    checks++;
    if (bresp !== 2'b00) begin failures++; $display("FAIL prio_bresp got=%b exp=00", bresp); end
    checks++;
    if (!rseen || rresp !== 2'b00 || rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL prio_rdata got=%h/%b exp=12345678/00", rdata, rresp);
    end
  endtask

  task automatic test_round_robin();
    int base;
    bit exp_g;
    do_reset();
    base = gq.size();
    fork
      begin
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        for (int i = 0; i < 4; i++) begin
          do_read(0, 32'h10, 0, d, r, ok);
          checks++;
          if (!ok || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rr_m0_data[%0d] got=%h exp=deadbeef", i, d); end
        end
      end
      begin
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        for (int i = 0; i < 4; i++) begin
          do_read(1, 32'h20, 0, d, r, ok);
          checks++;
          if (!ok || d !== 32'h1234_5678) begin failures++; $display("FAIL rr_m1_data[%0d] got=%h exp=12345678", i, d); end
        end
      end
    join
    checks++;
    if (gq.size() - base !== 8) begin failures++; $display("FAIL rr_grant_count got=%0d exp=8", gq.size() - base); end
    for (int i = 0; i < 8 && base + i < gq.size(); i++) begin
      exp_g = i[0];
      checks++;
      if (gq[base + i] !== exp_g) begin failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, gq[base + i], exp_g); end
    end
  endtask

  task automatic test_aw_delay();
    logic [1:0] resp; bit ok;
    int wb0, bb0;
    aw_delay = 3; cfg_bresp = 2'b10;
    wb0 = w_beats; bb0 = b0_cnt;
    do_write(0, 32'h30, 32'hA5A5_0F0F, 4'hC, resp, ok);
    aw_delay = 0; cfg_bresp = 2'b00;
    checks++;
    if (!ok || resp !== 2'b10) begin failures++; $display("FAIL awdly_bresp got=%b ok=%0d exp=10", resp, ok); end
    checks++;
    if (w_beats - wb0 !== 1) begin failures++; $display("FAIL awdly_w_beats got=%0d exp=1", w_beats - wb0); end
    checks++;
    if (b0_cnt - bb0 !== 1) begin failures++; $display("FAIL awdly_b_count got=%0d exp=1", b0_cnt - bb0); end
    checks++;
    if (sl_awaddr !== 32'h30 || sl_wstrb !== 4'hC) begin
      failures++; $display("FAIL awdly_slave_aw got=%h/%h exp=00000030/c", sl_awaddr, sl_wstrb);
    end
  endtask

  task automatic test_rready_hold();
    int base;
    base = gq.size();
    fork
      begin
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        do_read(0, 32'h10, 5, d, r, ok);
        checks++;
        if (!ok || d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_m0_data got=%h exp=deadbeef", d); end
      end
      begin
        logic [DW-1:0] d; logic [1:0] r; bit ok;
        repeat (2) @(negedge clk);
        do_read(1, 32'h20, 0, d, r, ok);
        checks++;
        if (!ok || d !== 32'h1234_5678) begin failures++; $display("FAIL hold_m1_data got=%h exp=12345678", d); end
      end
      begin
        int n; bit viol;
        n = 0; viol = 0;
        #1;
        while (!m_rvalid[0] && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 4; i++) begin
          @(negedge clk); #1;
          if (m_arready[1] || m_rvalid[1] || m_rdata[1] !== '0 || grant_o !== 1'b0 || !busy_o) viol = 1;
        end
        checks++;
        if (n >= 20 || viol) begin failures++; $display("FAIL hold_m1_blocked got=viol%0d/wait%0d exp=0/<20", viol, n); end
      end
    join
    checks++;
    if (gq.size() - base !== 2 || gq[base] !== 1'b0 || gq[base + 1] !== 1'b1) begin
      failures++; $display("FAIL hold_grant_order got=%0d entries exp=2 entries 0,1", gq.size() - base);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit got;
    r_block = 1'b1;
    m_araddr[0] = 32'h10; m_arvalid[0] = 1'b1; m_rready[0] = 1'b1;
    n = 0; got = 0;
    while (!got && n < 20) begin
      #1; got = m_arready[0];
      @(negedge clk); n++;
    end
    m_arvalid[0] = 1'b0;
    checks++;
    if (!got || busy_o !== 1'b1 || s_axi_rready !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_rresp got=ar%0d/busy%b/rready%b exp=1/1/1", got, busy_o, s_axi_rready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy_o); end
    checks++;
    if ({s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready} !== 5'b0) begin
      failures++; $display("FAIL rstmid_slave_valids got=%b exp=00000",
                           {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid, s_axi_bready, s_axi_rready});
    end
    checks++;
    if (m_rvalid[0] !== 1'b0 || grant_o !== 1'b0) begin
      failures++; $display("FAIL rstmid_master got=rvalid%b/grant%b exp=0/0", m_rvalid[0], grant_o);
    end
    @(negedge clk);
    rst = 1'b0; r_block = 1'b0; m_rready[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; aw_delay = 0; cfg_bresp = 2'b00; r_block = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_awaddr[m] = '0; m_araddr[m] = '0; m_awprot[m] = '0; m_arprot[m] = '0;
      m_wdata[m] = '0; m_wstrb[m] = '0; m_awvalid[m] = 1'b0; m_wvalid[m] = 1'b0;
      m_bready[m] = 1'b0; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_single_write();
    test_wr_rd_prio();
    test_round_robin();
    test_aw_delay();
    test_rready_hold();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
